// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: FSM states, PC-source selects, exception
// cause encodings and default handler vector addresses.
package cpu_ctrl_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned VEC_W   = 8;
  localparam int unsigned CAUSE_W = 2;
  localparam int unsigned PCSRC_W = 3;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned REQ_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SAVE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_RET   = 3'd4
  } exc_state_e;

  localparam logic [PCSRC_W-1:0] PCSRC_ULA    = 3'd0;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [PCSRC_W-1:0] PCSRC_CONCAT = 3'd2;
  localparam logic [PCSRC_W-1:0] PCSRC_MDR    = 3'd3;
  localparam logic [PCSRC_W-1:0] PCSRC_EPC    = 3'd4;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE   = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_OPCODE = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_OVF    = 2'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_DIV0   = 2'd3;

  localparam int unsigned VEC_OPCODE_DEF = 253;
  localparam int unsigned VEC_OVF_DEF    = 254;
  localparam int unsigned VEC_DIV0_DEF   = 255;

  typedef struct packed {
    logic [CAUSE_W-1:0] cause;
    logic [VEC_W-1:0]   vector;
  } exc_sel_t;

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority exception encoder: opcode > overflow > div0 -> {cause, vector}.
module exc_priority_enc
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned VEC_OPCODE = VEC_OPCODE_DEF,
  parameter int unsigned VEC_OVF    = VEC_OVF_DEF,
  parameter int unsigned VEC_DIV0   = VEC_DIV0_DEF
) (
  input  logic [REQ_W-1:0] req,
  output exc_sel_t         sel_c
);

  always_comb begin
    sel_c = '{cause: CAUSE_NONE, vector: '0};
    if (req[0]) begin
      sel_c = '{cause: CAUSE_OPCODE, vector: VEC_W'(VEC_OPCODE)};
    end else if (req[1]) begin
      sel_c = '{cause: CAUSE_OVF, vector: VEC_W'(VEC_OVF)};
    end else if (req[2]) begin
      sel_c = '{cause: CAUSE_DIV0, vector: VEC_W'(VEC_DIV0)};
    end
  end

endmodule

// File: rtl/exc_pc_sequencer.sv
// Exception entry / return sequencer: saves EPC, fetches the handler vector
// through memory/MDR and drives the PC-source select and PC write strobe.
module exc_pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned VEC_OPCODE = VEC_OPCODE_DEF,
  parameter int unsigned VEC_OVF    = VEC_OVF_DEF,
  parameter int unsigned VEC_DIV0   = VEC_DIV0_DEF,
  parameter int unsigned PC_OFFSET  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REQ_W-1:0]    exc_req,
  input  logic                eret,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic [DATA_W-1:0]   mdr_in,
  output logic                busy,
  output logic                epc_write,
  output logic [DATA_W-1:0]   epc_data,
  output logic                mem_read,
  output logic [DATA_W-1:0]   mem_addr,
  output logic                pc_write,
  output logic [PCSRC_W-1:0]  pc_source_control,
  output logic [CAUSE_W-1:0]  exc_cause
);

  exc_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  exc_sel_t            sel_c;
  logic [VEC_W-1:0]    vec, vec_nxt;
  logic                busy_nxt, epc_write_nxt, mem_read_nxt, pc_write_nxt;
  logic [PCSRC_W-1:0]  pcsrc_nxt;
  logic [DATA_W-1:0]   epc_data_nxt;
  logic [CAUSE_W-1:0]  cause_nxt;

  // The handler address reaches PC through the datapath MDR mux, not through here.
  logic unused_mdr;
  assign unused_mdr = ^mdr_in;

  exc_priority_enc #(
    .VEC_OPCODE (VEC_OPCODE),
    .VEC_OVF    (VEC_OVF),
    .VEC_DIV0   (VEC_DIV0)
  ) u_prio (
    .req   (exc_req),
    .sel_c (sel_c)
  );

  // State and wait-counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (|exc_req)  state_nxt = ST_SAVE;
        else if (eret) state_nxt = ST_RET;
      end
      ST_SAVE: begin
        state_nxt = ST_FETCH;
        cnt_nxt   = CNT_W'(MEM_LAT - 1);
      end
      ST_FETCH: begin
        if (cnt == '0) state_nxt = ST_LOAD;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_LOAD: state_nxt = ST_IDLE;
      ST_RET:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    busy_nxt      = (state_nxt != ST_IDLE);
    epc_write_nxt = 1'b0;
    mem_read_nxt  = 1'b0;
    pc_write_nxt  = 1'b0;
    pcsrc_nxt     = PCSRC_ULA;
    epc_data_nxt  = epc_data;
    vec_nxt       = vec;
    cause_nxt     = exc_cause;
    case (state_nxt)
      ST_SAVE:  epc_write_nxt = 1'b1;
      ST_FETCH: mem_read_nxt  = 1'b1;
      ST_LOAD: begin
        pc_write_nxt = 1'b1;
        pcsrc_nxt    = PCSRC_MDR;
      end
      ST_RET: begin
        pc_write_nxt = 1'b1;
        pcsrc_nxt    = PCSRC_EPC;
      end
      default: ;
    endcase
    if (state == ST_IDLE && state_nxt == ST_SAVE) begin
      epc_data_nxt = pc_in - DATA_W'(PC_OFFSET);
      vec_nxt      = sel_c.vector;
      cause_nxt    = sel_c.cause;
    end
    if (state == ST_IDLE && state_nxt == ST_RET) begin
      cause_nxt = CAUSE_NONE;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy              <= 1'b0;
      epc_write         <= 1'b0;
      mem_read          <= 1'b0;
      pc_write          <= 1'b0;
      pc_source_control <= PCSRC_ULA;
      epc_data          <= '0;
      vec               <= '0;
      exc_cause         <= CAUSE_NONE;
    end else begin
      busy              <= busy_nxt;
      epc_write         <= epc_write_nxt;
      mem_read          <= mem_read_nxt;
      pc_write          <= pc_write_nxt;
      pc_source_control <= pcsrc_nxt;
      epc_data          <= epc_data_nxt;
      vec               <= vec_nxt;
      exc_cause         <= cause_nxt;
    end
  end

  assign mem_addr = DATA_W'(vec);

endmodule

// File: tb/tb_exc_pc_sequencer.sv
// Bench for exc_pc_sequencer: two instances (MEM_LAT 2 and 1) share stimulus and
// are compared every cycle against a transaction-timeline reference model.
module tb_exc_pc_sequencer;

  localparam int NI   = 2;
  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic [2:0]  exc_req = '0;
  logic        eret    = 1'b0;
  logic [31:0] pc_in   = '0;
  logic [31:0] mdr_in  = '0;

  logic        busy      [NI];
  logic        epc_write [NI];
  logic        mem_read  [NI];
  logic        pc_write  [NI];
  logic [31:0] epc_data  [NI];
  logic [31:0] mem_addr  [NI];
  logic [2:0]  pcsrc     [NI];
  logic [1:0]  exc_cause [NI];

  exc_pc_sequencer #(.MEM_LAT(LAT0)) dut_a (
    .clk(clk), .reset(reset), .exc_req(exc_req), .eret(eret), .pc_in(pc_in),
    .mdr_in(mdr_in), .busy(busy[0]), .epc_write(epc_write[0]), .epc_data(epc_data[0]),
    .mem_read(mem_read[0]), .mem_addr(mem_addr[0]), .pc_write(pc_write[0]),
    .pc_source_control(pcsrc[0]), .exc_cause(exc_cause[0])
  );

  exc_pc_sequencer #(.MEM_LAT(LAT1)) dut_b (
    .clk(clk), .reset(reset), .exc_req(exc_req), .eret(eret), .pc_in(pc_in),
    .mdr_in(mdr_in), .busy(busy[1]), .epc_write(epc_write[1]), .epc_data(epc_data[1]),
    .mem_read(mem_read[1]), .mem_addr(mem_addr[1]), .pc_write(pc_write[1]),
    .pc_source_control(pcsrc[1]), .exc_cause(exc_cause[1])
  );

  always #5 clk = ~clk;

  int     checks   = 0;
  int     failures = 0;
  longint n        = 0;

  // Model: each accepted request occupies edges [m_start, m_end]; outputs follow
  // from the offset of the current cycle within that window.
  int          lat     [NI];
  longint      m_start [NI];
  longint      m_end   [NI];
  int          m_kind  [NI];  // 1 = exception, 2 = eret
  logic [1:0]  m_cause [NI];
  logic [31:0] m_epc   [NI];
  logic [31:0] m_addr  [NI];

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_start[i] = -100;
      m_end[i]   = -100;
      m_kind[i]  = 0;
      m_cause[i] = 2'd0;
      m_epc[i]   = '0;
      m_addr[i]  = '0;
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      if (n - 1 > m_end[i]) begin
        if (exc_req != 3'b000) begin
          m_start[i] = n;
          m_end[i]   = n + lat[i] + 1;
          m_kind[i]  = 1;
          m_epc[i]   = pc_in - 32'd4;
          if (exc_req[0]) begin
            m_cause[i] = 2'd1; m_addr[i] = 32'd253;
          end else if (exc_req[1]) begin
            m_cause[i] = 2'd2; m_addr[i] = 32'd254;
          end else begin
            m_cause[i] = 2'd3; m_addr[i] = 32'd255;
          end
        end else if (eret) begin
          m_start[i] = n;
          m_end[i]   = n;
          m_kind[i]  = 2;
          m_cause[i] = 2'd0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      longint d;
      bit b, ex, e_epcw, e_mrd, e_pcw;
      logic [2:0] e_src;
      d      = n - m_start[i];
      b      = (n >= m_start[i]) && (n <= m_end[i]);
      ex     = b && (m_kind[i] == 1);
      e_epcw = ex && (d == 0);
      e_mrd  = ex && (d >= 1) && (d <= lat[i]);
      e_pcw  = (ex && (d == lat[i] + 1)) || (b && m_kind[i] == 2);
      e_src  = e_pcw ? ((m_kind[i] == 1) ? 3'b011 : 3'b100) : 3'b000;
      check_eq($sformatf("busy%0d", i),      32'(busy[i]),      32'(b));
      check_eq($sformatf("epc_write%0d", i), 32'(epc_write[i]), 32'(e_epcw));
      check_eq($sformatf("mem_read%0d", i),  32'(mem_read[i]),  32'(e_mrd));
      check_eq($sformatf("pc_write%0d", i),  32'(pc_write[i]),  32'(e_pcw));
      check_eq($sformatf("pcsrc%0d", i),     32'(pcsrc[i]),     32'(e_src));
      check_eq($sformatf("epc_data%0d", i),  epc_data[i],       m_epc[i]);
      check_eq($sformatf("mem_addr%0d", i),  mem_addr[i],       m_addr[i]);
      check_eq($sformatf("exc_cause%0d", i), 32'(exc_cause[i]), 32'(m_cause[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(logic [2:0] r, logic e, logic [31:0] pc);
    exc_req = r;
    eret    = e;
    pc_in   = pc;
    mdr_in  = $urandom;
  endtask

  // Asynchronous reset mid-cycle, checked before the next clock edge
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    check_outputs();
    step();
    reset = 1'b1;
  endtask

  task automatic idle_steps(int k);
    drive(3'b000, 1'b0, $urandom);
    for (int j = 0; j < k; j++) step();
  endtask

  initial begin
    lat[0] = LAT0;
    lat[1] = LAT1;
    model_reset();
    #1 reset = 1'b0;
    #1 check_outputs();
    step();
    step();
    reset = 1'b1;
    idle_steps(2);

    // Overflow entry
    drive(3'b010, 1'b0, 32'h0000_0040); step();
    idle_steps(5);

    // Exception wins over simultaneous eret
    drive(3'b101, 1'b1, 32'h0000_1000); step();
    idle_steps(5);

    // Exception return
    drive(3'b000, 1'b1, 32'h0000_2000); step();
    idle_steps(3);

    // Busy lockout, then a held div0 request re-triggers after LOAD
    drive(3'b010, 1'b0, 32'h0000_0100); step();
    drive(3'b100, 1'b0, 32'h0000_0200);
    for (int j = 0; j < 9; j++) step();
    idle_steps(6);

    // EPC wrap-around
    drive(3'b001, 1'b0, 32'h0000_0002); step();
    idle_steps(5);

    // Reset during the first FETCH cycle
    drive(3'b010, 1'b0, 32'h0000_0080); step();
    drive(3'b000, 1'b0, 32'h0000_0090); step();
    pulse_reset();
    idle_steps(5);

    // Random traffic
    for (int j = 0; j < 500; j++) begin
      drive(($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
            ($urandom_range(0, 4) == 0), $urandom);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else step();
    end
    idle_steps(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
